// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared accumulator CPU widths, opcodes and fetch/decode state encoding
package cpu_defs;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 3;
    localparam int INS_W  = OP_W + ADDR_W;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;
endpackage

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - instruction fetch/decode stage: IR capture, branch resolve, wrong-path squash, halt
module fetch_decode #(
    parameter int ADDR_W = cpu_defs::ADDR_W,
    parameter int OP_W   = cpu_defs::OP_W,
    parameter int INS_W  = cpu_defs::INS_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              rmem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [INS_W-1:0]  mem_data,
    input  logic              acc_zero,
    output logic [INS_W-1:0]  ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic [OP_W-1:0]   opcode,
    output logic [ADDR_W-1:0] operand,
    output logic              load,
    output logic [ADDR_W-1:0] pc_tgt,
    output logic              halted
);
    import cpu_defs::*;

    state_t            state;
    logic              fv_q;
    logic [ADDR_W-1:0] fa_q;
    logic              squash_q;
    logic [ADDR_W-1:0] hlt_tgt_q;
    logic              run;
    logic              hlt_now;
    logic              take;
    logic              cap;

    assign run     = (state == ST_RUN);
    assign opcode  = ir[INS_W-1:ADDR_W];
    assign operand = ir[ADDR_W-1:0];

    assign hlt_now = run & ir_valid & (opcode == OP_HLT);
    assign take    = run & ir_valid & ((opcode == OP_JMP) | ((opcode == OP_JZ) & acc_zero));
    assign halted  = hlt_now | ~run;
    assign load    = take | halted;
    // Halt target is live from ir_pc during the HLT cycle, then held in hlt_tgt_q.
    assign pc_tgt  = !run    ? hlt_tgt_q :
                     hlt_now ? ir_pc + ADDR_W'(1) : operand;

    assign mem_addr = pc;
    assign mem_rd   = rmem & reset & ~halted;
    // The word returning during a take cycle is wrong-path; squash_q drops the following one.
    assign cap      = fv_q & ~squash_q & ~take & ~halted;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            fv_q      <= 1'b0;
            fa_q      <= '0;
            squash_q  <= 1'b0;
            hlt_tgt_q <= '0;
            ir        <= '0;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
        end else begin
            fv_q     <= mem_rd;
            fa_q     <= pc;
            squash_q <= take;
            ir_valid <= cap;
            if (cap) begin
                ir    <= mem_data;
                ir_pc <= fa_q;
            end
            if (hlt_now) begin
                state     <= ST_HALT;
                hlt_tgt_q <= ir_pc + ADDR_W'(1);
            end
        end
    end
endmodule
